// File: rtl/btle_whiten_ctrl_if.sv
// Serial bit-stream links of the whitening controller:
// upstream bits, scramble_core hookup and downstream bits.
interface btle_whiten_ctrl_if #(
   parameter int CHANNEL_NUMBER_BIT_WIDTH = 6
);
   logic                                bit_in;
   logic                                bit_in_valid;
   logic                                bit_in_ready;
   logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] scr_channel_number;
   logic                                scr_channel_number_load;
   logic                                scr_data_in;
   logic                                scr_data_in_valid;
   logic                                scr_data_out;
   logic                                scr_data_out_valid;
   logic                                bit_out;
   logic                                bit_out_valid;

   modport master (
      input  bit_in,
      input  bit_in_valid,
      output bit_in_ready,
      output scr_channel_number,
      output scr_channel_number_load,
      output scr_data_in,
      output scr_data_in_valid,
      input  scr_data_out,
      input  scr_data_out_valid,
      output bit_out,
      output bit_out_valid
   );

   modport slave (
      output bit_in,
      output bit_in_valid,
      input  bit_in_ready,
      input  scr_channel_number,
      input  scr_channel_number_load,
      input  scr_data_in,
      input  scr_data_in_valid,
      output scr_data_out,
      output scr_data_out_valid,
      input  bit_out,
      input  bit_out_valid
   );
endinterface

// File: rtl/btle_whiten_ctrl.sv
// BLE packet whitening sequencer: preamble/AA pass raw,
// header, payload and CRC are routed through scramble_core.
module btle_whiten_ctrl #(
   parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
   parameter int LEN_BIT_WIDTH            = 8,
   parameter int RAW_BITS                 = 40,
   parameter int HDR_BITS                 = 16,
   parameter int CRC_BITS                 = 24
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                abort,
   input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
   input  logic [LEN_BIT_WIDTH-1:0]            pdu_len,
   output logic                                busy,
   output logic                                done,
   btle_whiten_ctrl_if.master                  bus
);
   localparam int CW = LEN_BIT_WIDTH + 4;
   localparam logic [CW-1:0] RAW_LAST = CW'(RAW_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RAW,
      S_WHITEN,
      S_DRAIN
   } state_e;

   state_e                              state_q;
   logic [CW-1:0]                       cnt_q;
   logic [CW-1:0]                       tot_q;
   logic [CW-1:0]                       tot_d;
   logic [CW-1:0]                       cnt_d;
   logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] ch_q;
   logic                                busy_q;
   logic                                done_q;
   logic                                bit_q;
   logic                                vld_q;
   logic                                in_raw;
   logic                                in_white;
   logic                                accept;

   assign in_raw   = (state_q == S_RAW);
   assign in_white = (state_q == S_WHITEN);
   assign accept   = bus.bit_in_valid & bus.bit_in_ready;
   assign tot_d    = CW'(HDR_BITS + CRC_BITS) + (CW'(pdu_len) << 3);
   assign cnt_d    = cnt_q + CW'(1);

   assign bus.bit_in_ready            = in_raw | in_white;
   assign bus.scr_channel_number_load = (state_q == S_LOAD);
   assign bus.scr_channel_number      = ch_q;
   assign bus.scr_data_in             = bus.bit_in;
   assign bus.scr_data_in_valid       = accept & in_white;
   assign bus.bit_out                 = bit_q;
   assign bus.bit_out_valid           = vld_q;
   assign busy                        = busy_q;
   assign done                        = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tot_q   <= '0;
         ch_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bit_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         vld_q  <= 1'b0;
         if (abort && state_q != S_IDLE) begin
            // in-flight core output is dropped with the packet
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (start) begin
                     ch_q    <= channel_number;
                     tot_q   <= tot_d;
                     busy_q  <= 1'b1;
                     state_q <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  cnt_q   <= '0;
                  state_q <= S_RAW;
               end
               S_RAW: begin
                  if (accept) begin
                     bit_q <= bus.bit_in;
                     vld_q <= 1'b1;
                     if (cnt_q == RAW_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_WHITEN;
                     end else begin
                        cnt_q <= cnt_d;
                     end
                  end
               end
               S_WHITEN: begin
                  if (bus.scr_data_out_valid) begin
                     bit_q <= bus.scr_data_out;
                     vld_q <= 1'b1;
                  end
                  if (accept) begin
                     cnt_q <= cnt_d;
                     if (cnt_q == tot_q - CW'(1)) begin
                        state_q <= S_DRAIN;
                     end
                  end
               end
               S_DRAIN: begin
                  bit_q   <= bus.scr_data_out;
                  vld_q   <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_btle_whiten_ctrl.sv
// Bench for btle_whiten_ctrl: stand-in scramble_core plus a
// packet-level reference of raw and whitened output bits.
module tb_btle_whiten_ctrl;
   localparam int CHW   = 6;
   localparam int LW    = 8;
   localparam int LIMIT = 20000;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic           abort;
   logic [CHW-1:0] channel_number;
   logic [LW-1:0]  pdu_len;
   logic           busy;
   logic           done;

   btle_whiten_ctrl_if #(.CHANNEL_NUMBER_BIT_WIDTH(CHW)) bus ();

   btle_whiten_ctrl #(
      .CHANNEL_NUMBER_BIT_WIDTH(CHW),
      .LEN_BIT_WIDTH(LW),
      .RAW_BITS(40),
      .HDR_BITS(16),
      .CRC_BITS(24)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .channel_number(channel_number),
      .pdu_len(pdu_len),
      .busy(busy),
      .done(done),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   // stand-in for scramble_core: x^7+x^4+1, one-cycle latency
   logic [6:0] core_r;
   always @(posedge clk) begin
      if (rst) begin
         core_r                 <= '0;
         bus.scr_data_out       <= 1'b0;
         bus.scr_data_out_valid <= 1'b0;
      end else begin
         bus.scr_data_out_valid <= 1'b0;
         if (bus.scr_channel_number_load) begin
            core_r <= {bus.scr_channel_number[0], bus.scr_channel_number[1],
                       bus.scr_channel_number[2], bus.scr_channel_number[3],
                       bus.scr_channel_number[4], bus.scr_channel_number[5],
                       1'b1};
         end else if (bus.scr_data_in_valid) begin
            bus.scr_data_out       <= bus.scr_data_in ^ core_r[6];
            bus.scr_data_out_valid <= 1'b1;
            core_r <= {core_r[5:0], core_r[6]} ^ {2'b0, core_r[6], 4'b0};
         end
      end
   end

   bit wseq [2080];

   task automatic gen_wseq(input int ch, input int n);
      int p [7];
      int o;
      p[0] = 1;
      for (int i = 1; i < 7; i++) p[i] = (ch >> (6 - i)) & 1;
      for (int j = 0; j < n; j++) begin
         o       = p[6];
         wseq[j] = o[0];
         for (int i = 6; i > 0; i--) p[i] = p[i-1];
         p[0] = o;
         p[4] = p[4] ^ o;
      end
   endtask

   typedef enum {M_IDLE, M_LOAD, M_STREAM, M_DRAIN} mph_t;
   typedef struct {
      bit b;
      int due;
      bit last;
   } exp_t;

   mph_t     m_phase = M_IDLE;
   bit       m_busy  = 1'b0;
   bit [5:0] m_ch    = '0;
   int       m_total = 0;
   int       m_k     = 0;
   int       m_acc   = 0;
   exp_t     expq [$];

   // packet-level reference: bit k is raw below 40, else
   // bit ^ whitening sequence; raw due next cycle, whitened one later
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_phase = M_IDLE;
         m_busy  = 1'b0;
         m_ch    = '0;
         expq.delete();
      end else if (m_phase != M_IDLE && abort) begin
         m_phase = M_IDLE;
         m_busy  = 1'b0;
         expq.delete();
      end else begin
         case (m_phase)
            M_IDLE: if (start) begin
               m_ch    = channel_number;
               m_total = 80 + 8 * int'(pdu_len);
               gen_wseq(int'(channel_number), m_total - 40);
               m_busy  = 1'b1;
               m_acc   = 0;
               m_phase = M_LOAD;
            end
            M_LOAD: begin
               m_k     = 0;
               m_phase = M_STREAM;
            end
            M_STREAM: if (bus.bit_in_valid) begin
               if (m_k < 40) expq.push_back('{bus.bit_in, cyc, 1'b0});
               else expq.push_back('{bus.bit_in ^ wseq[m_k-40], cyc + 1,
                                     m_k == m_total - 1});
               m_k++;
               m_acc++;
               if (m_k == m_total) m_phase = M_DRAIN;
            end
            M_DRAIN: begin
               m_busy  = 1'b0;
               m_phase = M_IDLE;
            end
            default: m_phase = M_IDLE;
         endcase
      end
   end

   bit       obs_bits [$];
   int       n_loads = 0;
   int       n_done  = 0;
   int       obs_acc = 0;
   int       last_vld_cyc = -1;
   int       done_cyc = -2;
   bit       busy_at_done = 1'b1;
   bit [5:0] load_ch = '0;
   int       load_cycs [$];
   int       done_cycs [$];

   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         bit   ev;
         bit   ed;
         while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
         ev = (expq.size() > 0) && (expq[0].due == cyc);
         ed = 1'b0;
         chk("bit_out_valid", 32'(bus.bit_out_valid), 32'(ev));
         if (ev && bus.bit_out_valid) begin
            e  = expq.pop_front();
            ed = e.last;
            chk("bit_out", 32'(bus.bit_out), 32'(e.b));
         end
         chk("done", 32'(done), 32'(ed));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("bit_in_ready", 32'(bus.bit_in_ready), 32'(m_phase == M_STREAM));
         chk("ch_load", 32'(bus.scr_channel_number_load), 32'(m_phase == M_LOAD));
         chk("scr_ch", 32'(bus.scr_channel_number), 32'(m_ch));
         chk("scr_in_valid", 32'(bus.scr_data_in_valid),
             32'(m_phase == M_STREAM && m_k >= 40 && bus.bit_in_valid));
         if (bus.scr_channel_number_load) begin
            n_loads++;
            load_ch = bus.scr_channel_number;
            load_cycs.push_back(cyc);
         end
         if (bus.bit_out_valid) begin
            obs_bits.push_back(bus.bit_out);
            last_vld_cyc = cyc;
         end
         if (done) begin
            n_done++;
            done_cyc     = cyc;
            busy_at_done = busy;
            done_cycs.push_back(cyc);
         end
         if (bus.bit_in_valid && bus.bit_in_ready) obs_acc++;
      end
   end

   task automatic clear_stats();
      obs_bits.delete();
      n_loads = 0;
      n_done  = 0;
      obs_acc = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.bit_in_valid = 1'($urandom_range(1));
         bus.bit_in       = 1'($urandom_range(1));
         @(posedge clk); #2;
      end
      bus.bit_in_valid = 1'b0;
   endtask

   task automatic run_pkt(input int ch, input int len, input int gap,
                          input bit zeros, input int abort_at,
                          input bit mid);
      int budget;
      bit mid_sent;
      budget         = 0;
      mid_sent       = 1'b0;
      channel_number = CHW'(ch);
      pdu_len        = LW'(len);
      start          = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      while (m_phase != M_IDLE && budget < LIMIT) begin
         bus.bit_in_valid = (int'($urandom_range(99)) >= gap);
         bus.bit_in       = zeros ? 1'b0 : 1'($urandom_range(1));
         if (abort_at >= 0 && m_acc == abort_at) begin
            abort            = 1'b1;
            bus.bit_in_valid = 1'b1;
         end
         if (mid && !mid_sent && m_acc == 60) begin
            start          = 1'b1;
            channel_number = 6'd5;
            pdu_len        = 8'd7;
            mid_sent       = 1'b1;
         end
         @(posedge clk); #2;
         abort = 1'b0;
         start = 1'b0;
         budget++;
      end
      bus.bit_in_valid = 1'b0;
      chk("pkt_timeout", 32'(budget < LIMIT), 32'd1);
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   initial begin
      int ones;
      bit [7:0] pat;
      rst              = 1'b1;
      start            = 1'b1;
      abort            = 1'b0;
      channel_number   = 6'd0;
      pdu_len          = 8'd0;
      bus.bit_in       = 1'b1;
      bus.bit_in_valid = 1'b1;

      gen_wseq(37, 8);
      chk("model_pin_ch37", 32'({wseq[0], wseq[1], wseq[2], wseq[3],
                                 wseq[4], wseq[5], wseq[6], wseq[7]}), 32'hB1);

      @(posedge clk); #2;
      chk_en = 1'b1;
      @(posedge clk); #2;
      settle();
      chk("reset_outs", 32'({busy, done, bus.bit_in_ready,
                             bus.scr_channel_number_load, bus.scr_data_in_valid,
                             bus.bit_out, bus.bit_out_valid}), 32'd0);
      chk("reset_ch", 32'(bus.scr_channel_number), 32'd0);
      chk("reset_loads", 32'(n_loads), 32'd0);
      @(posedge clk); #2;
      rst              = 1'b0;
      start            = 1'b0;
      bus.bit_in_valid = 1'b0;
      idle(3);

      clear_stats();
      run_pkt(37, 0, 0, 1'b1, -1, 1'b0);
      settle();
      ones = 0;
      for (int i = 0; i < 40; i++) ones += int'(obs_bits[i]);
      for (int i = 0; i < 8; i++) pat[7-i] = obs_bits[40+i];
      chk("ch37_loads", 32'(n_loads), 32'd1);
      chk("ch37_load_ch", 32'(load_ch), 32'd37);
      chk("ch37_total_bits", 32'(obs_bits.size()), 32'd80);
      chk("ch37_raw_ones", 32'(ones), 32'd0);
      chk("ch37_white_head", 32'(pat), 32'hB1);
      chk("ch37_white_bits", 32'(obs_bits.size() - 40), 32'd40);
      chk("ch37_done_with_last", 32'(done_cyc), 32'(last_vld_cyc));
      chk("ch37_busy_at_done", 32'(busy_at_done), 32'd0);

      idle(4);
      clear_stats();
      run_pkt(0, 255, 40, 1'b0, -1, 1'b0);
      settle();
      chk("ch0_accepts", 32'(obs_acc), 32'd2120);
      chk("ch0_total_bits", 32'(obs_bits.size()), 32'd2120);
      chk("ch0_loads", 32'(n_loads), 32'd1);
      chk("ch0_done", 32'(n_done), 32'd1);

      idle(4);
      clear_stats();
      run_pkt(37, 3, 20, 1'b0, -1, 1'b1);
      settle();
      chk("mid_total_bits", 32'(obs_bits.size()), 32'd104);
      chk("mid_loads", 32'(n_loads), 32'd1);
      chk("mid_load_ch", 32'(load_ch), 32'd37);
      chk("mid_done", 32'(n_done), 32'd1);

      idle(4);
      clear_stats();
      run_pkt(12, 4, 30, 1'b0, 50, 1'b0);
      settle();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(bus.bit_in_ready), 32'd0);
      chk("abort_vld", 32'(bus.bit_out_valid), 32'd0);
      chk("abort_no_done", 32'(n_done), 32'd0);
      idle(3);
      clear_stats();
      run_pkt(20, 2, 25, 1'b0, -1, 1'b0);
      settle();
      chk("post_abort_loads", 32'(n_loads), 32'd1);
      chk("post_abort_bits", 32'(obs_bits.size()), 32'd96);
      chk("post_abort_done", 32'(n_done), 32'd1);

      idle(4);
      clear_stats();
      load_cycs.delete();
      done_cycs.delete();
      run_pkt(9, 1, 10, 1'b0, -1, 1'b0);
      run_pkt(33, 2, 10, 1'b0, -1, 1'b0);
      settle();
      chk("b2b_done", 32'(n_done), 32'd2);
      chk("b2b_loads", 32'(n_loads), 32'd2);
      chk("b2b_bits", 32'(obs_bits.size()), 32'd184);
      chk("b2b_load_after_done", 32'(load_cycs[1]), 32'(done_cycs[0] + 1));

      idle(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
